// File: rtl/smac_ac_pkg.sv
`default_nettype none
// ============================================================================
//  smac_ac_pkg : shared types, width helper and saturation limits for the
//                SMAC accumulate (AC3) stage.
//  Revision    : 1.0
// ============================================================================
package smac_ac_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SHIFT = 2'd2,
    OUT   = 2'd3
  } ac3_state_t;

  // Saturation limits for the default 8-bit activation precision.
  localparam int                       AC3_PA_DEF  = 8;
  localparam logic signed [AC3_PA_DEF-1:0] AC3_SAT_MAX = 8'sd127;
  localparam logic signed [AC3_PA_DEF-1:0] AC3_SAT_MIN = -8'sd128;

  function automatic int acc_w(input int m, input int pa, input int pw, input int mno);
    return $clog2(m) + pa + pw + $clog2(mno);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ac3_lane.sv
`default_nettype none
// ============================================================================
//  ac3_lane : one accumulation channel -- clear/add/shift accumulator and
//             Pa-bit narrowing (saturating when AC3_SAT_EN is defined).
//  Revision : 1.0
// ============================================================================
module ac3_lane #(
  parameter int ACC_W = 25,
  parameter int PA    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add,
  input  logic             shift,
  input  logic [ACC_W-1:0] in_data,
  output logic [PA-1:0]    out_data
);

  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add) begin
      acc_d = acc_q + in_data;
    end else if (shift) begin
      acc_d = {acc_q[ACC_W-1], acc_q[ACC_W-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

`ifdef AC3_SAT_EN
  // The value fits in PA bits when every bit from PA-1 upward equals the sign.
  logic [ACC_W-PA:0] hi_bits;
  logic              fits;

  assign hi_bits = acc_q[ACC_W-1:PA-1];
  assign fits    = (hi_bits == '0) || (hi_bits == '1);

  always_comb begin
    out_data = acc_q[PA-1:0];
    if (!fits) begin
      out_data = acc_q[ACC_W-1] ? {1'b1, {(PA-1){1'b0}}} : {1'b0, {(PA-1){1'b1}}};
    end
  end
`else
  logic unused_hi_bits;

  assign unused_hi_bits = ^acc_q[ACC_W-1:PA];
  assign out_data       = acc_q[PA-1:0];
`endif

endmodule
`default_nettype wire

// File: rtl/ac3_quant_accumulator.sv
`default_nettype none
// ============================================================================
//  ac3_quant_accumulator : N_CH-channel partial-sum accumulator with serial
//                          quantizing right shift and valid/ready output.
//                          Optional saturation: define AC3_SAT_EN.
//  Revision              : 1.0
// ============================================================================
module ac3_quant_accumulator
  import smac_ac_pkg::*;
#(
  parameter  int M      = 16,
  parameter  int PA     = 8,
  parameter  int PW     = 4,
  parameter  int MNO    = 288,
  parameter  int N_CH   = 4,
  localparam int ACC_W  = acc_w(M, PA, PW, MNO),
  localparam int NOPS_W = $clog2(MNO + 1),
  localparam int QS_W   = $clog2(ACC_W)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NOPS_W-1:0]     num_ops,
  input  logic [QS_W-1:0]       qshift,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_CH*ACC_W-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_CH*PA-1:0]    out_data,
  output logic                  busy,
  output logic                  done
);

  localparam logic [NOPS_W-1:0] OP_ONE = NOPS_W'(1);
  localparam logic [QS_W-1:0]   SH_ONE = QS_W'(1);

  ac3_state_t        state_d, state_q;
  logic [NOPS_W-1:0] num_ops_d, num_ops_q;
  logic [QS_W-1:0]   qshift_d, qshift_q;
  logic [NOPS_W-1:0] op_cnt_d, op_cnt_q;
  logic [QS_W-1:0]   shift_cnt_d, shift_cnt_q;
  logic [NOPS_W-1:0] op_cnt_inc;
  logic [QS_W-1:0]   shift_cnt_inc;
  logic              lane_clr, lane_add, lane_shift;

  assign op_cnt_inc    = op_cnt_q + OP_ONE;
  assign shift_cnt_inc = shift_cnt_q + SH_ONE;

  always_comb begin
    state_d     = state_q;
    num_ops_d   = num_ops_q;
    qshift_d    = qshift_q;
    op_cnt_d    = op_cnt_q;
    shift_cnt_d = shift_cnt_q;
    lane_clr    = 1'b0;
    lane_add    = 1'b0;
    lane_shift  = 1'b0;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          num_ops_d   = num_ops;
          qshift_d    = qshift;
          op_cnt_d    = '0;
          shift_cnt_d = '0;
          lane_clr    = 1'b1;
          // An empty accumulation skips straight to presenting zeros.
          state_d     = (num_ops == '0) ? OUT : ACCUM;
        end
      end
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) begin
          lane_add = 1'b1;
          op_cnt_d = op_cnt_inc;
          if (op_cnt_inc == num_ops_q) begin
            state_d = (qshift_q == '0) ? OUT : SHIFT;
          end
        end
      end
      SHIFT: begin
        lane_shift  = 1'b1;
        shift_cnt_d = shift_cnt_inc;
        if (shift_cnt_inc == qshift_q) begin
          state_d = OUT;
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      num_ops_q   <= '0;
      qshift_q    <= '0;
      op_cnt_q    <= '0;
      shift_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      num_ops_q   <= num_ops_d;
      qshift_q    <= qshift_d;
      op_cnt_q    <= op_cnt_d;
      shift_cnt_q <= shift_cnt_d;
    end
  end

  assign busy = (state_q != IDLE);

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    ac3_lane #(
      .ACC_W (ACC_W),
      .PA    (PA)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .clr      (lane_clr),
      .add      (lane_add),
      .shift    (lane_shift),
      .in_data  (in_data[c*ACC_W +: ACC_W]),
      .out_data (out_data[c*PA +: PA])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_ac3_quant_accumulator.sv
`default_nettype none
// ============================================================================
//  tb_ac3_quant_accumulator : directed bench with a behavioural sum/shift/
//                             narrow model and a per-cycle output checker.
//  Revision                 : 1.0
// ============================================================================
module tb_ac3_quant_accumulator;
  import smac_ac_pkg::*;

  localparam int ACC_W  = 25;
  localparam int PA     = 8;
  localparam int NCH    = 4;
  localparam int NOPS_W = 9;
  localparam int QS_W   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [NOPS_W-1:0]    num_ops;
  logic [QS_W-1:0]      qshift;
  logic                 in_valid;
  logic                 in_ready;
  logic [NCH*ACC_W-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH*PA-1:0]    out_data;
  logic                 busy;
  logic                 done;

  always #5 clk = ~clk;

  ac3_quant_accumulator dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .qshift    (qshift),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  int                vec_cnt  = 0;
  int                err_cnt  = 0;
  int                done_cnt = 0;
  longint            beat [16][NCH];
  bit                vpat [16];
  logic [NCH*PA-1:0] exp_q [$];
  logic [NCH*PA-1:0] last_out;
  logic [NCH*PA-1:0] prev_data;
  bit                prev_hold = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    vec_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Sum wrapped to ACC_W bits, floor-divided by 2^q, then narrowed to PA bits.
  function automatic longint narrow(input longint sum, input int q);
    longint w;
    w = sum & ((longint'(1) << ACC_W) - 1);
    if (w >= (longint'(1) << (ACC_W - 1))) w = w - (longint'(1) << ACC_W);
    w = w >>> q;
`ifdef AC3_SAT_EN
    if (w > longint'(AC3_SAT_MAX)) w = longint'(AC3_SAT_MAX);
    if (w < longint'(AC3_SAT_MIN)) w = longint'(AC3_SAT_MIN);
`else
    w = w & ((longint'(1) << PA) - 1);
    if (w >= (longint'(1) << (PA - 1))) w = w - (longint'(1) << PA);
`endif
    return w;
  endfunction

  function automatic logic [NCH*PA-1:0] pack_exp(input longint sums [NCH], input int q);
    logic [NCH*PA-1:0] r;
    longint            n;
    r = '0;
    for (int c = 0; c < NCH; c++) begin
      n = narrow(sums[c], q);
      r[c*PA +: PA] = n[PA-1:0];
    end
    return r;
  endfunction

  function automatic longint chan(input logic [NCH*PA-1:0] v, input int c);
    logic signed [PA-1:0] t;
    t = v[c*PA +: PA];
    return longint'(t);
  endfunction

  task automatic clear_pat();
    for (int i = 0; i < 16; i++) begin
      vpat[i] = 1'b0;
      for (int c = 0; c < NCH; c++) beat[i][c] = 0;
    end
  endtask

  // Output checker: handshake data against the model queue, hold stability, pulse rules.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      chk("done_vs_handshake", longint'(done), longint'(out_valid & out_ready));
      chk("in_ready_vs_out_valid", longint'(in_ready & out_valid), 0);
      if (prev_hold) chk("out_data_stable", longint'(out_data), longint'(prev_data));
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          chk("out_data", longint'(out_data), longint'(exp_q.pop_front()));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
    end
  end

  task automatic run(input string name, input int nops, input int q, input int plen, input int hold);
    longint sums [NCH];
    int     acc_n    = 0;
    int     last     = -1;
    int     first_ov = -1;
    int     dcnt;
    for (int c = 0; c < NCH; c++) sums[c] = 0;
    start   = 1'b1;
    num_ops = NOPS_W'(nops);
    qshift  = QS_W'(q);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 0; cyc < plen + 64; cyc++) begin
      if (cyc < plen) begin
        in_valid = vpat[cyc];
        for (int c = 0; c < NCH; c++) in_data[c*ACC_W +: ACC_W] = beat[cyc][c][ACC_W-1:0];
        if (vpat[cyc] && acc_n < nops) begin
          acc_n++;
          last = cyc;
          for (int c = 0; c < NCH; c++) sums[c] += beat[cyc][c];
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (first_ov >= 0 && cyc >= plen - 1) break;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk({name, " latency"}, first_ov, (nops == 0) ? 0 : last + 1 + q);
    if (first_ov < 0) begin
      rst = 1'b1; #1; rst = 1'b0;
      return;
    end
    for (int h = 0; h < hold; h++) begin
      start = 1'b1;
      @(posedge clk); #1;
      chk({name, " held_valid"}, longint'(out_valid), 1);
    end
    start = 1'b0;
    exp_q.push_back(pack_exp(sums, q));
    dcnt      = done_cnt;
    out_ready = 1'b1;
    #1;
    chk({name, " done"}, longint'(done), 1);
    last_out = out_data;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({name, " done_once"}, done_cnt - dcnt, 1);
    chk({name, " idle_after"}, longint'(busy | out_valid | done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_ops   = '0;
    qshift    = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    clear_pat();
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", longint'(busy), 0);
    chk("reset in_ready", longint'(in_ready), 0);
    chk("reset out_valid", longint'(out_valid), 0);
    chk("reset done", longint'(done), 0);
    chk("reset out_data", longint'(out_data), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // T1
    clear_pat();
    for (int i = 0; i < 3; i++) begin
      vpat[i]    = 1'b1;
      beat[i][0] = 10 * (i + 1);
      beat[i][1] = i + 1;
    end
    run("T1", 3, 2, 3, 0);
    chk("T1 ch0", chan(last_out, 0), 15);
    chk("T1 ch1", chan(last_out, 1), 1);

    // T2
    clear_pat();
    vpat[0] = 1'b1; beat[0][1] = -7;
    vpat[1] = 1'b1; beat[1][1] = -6;
    run("T2", 2, 1, 2, 0);
    chk("T2 ch1", chan(last_out, 1), -7);

    // T3
    clear_pat();
    vpat[0] = 1'b1; beat[0][2] = 200; beat[0][3] = -200;
    vpat[1] = 1'b1; beat[1][2] = 100; beat[1][3] = -100;
    run("T3", 2, 0, 2, 0);
`ifdef AC3_SAT_EN
    chk("T3 ch2", chan(last_out, 2), 127);
    chk("T3 ch3", chan(last_out, 3), -128);
`else
    chk("T3 ch2", chan(last_out, 2), 44);
    chk("T3 ch3", chan(last_out, 3), -44);
`endif

    // T4: gaps, extra valid beats after completion must be ignored
    clear_pat();
    vpat[0] = 1'b1; beat[0][0] = 1;
    vpat[1] = 1'b0; beat[1][0] = 100;
    vpat[2] = 1'b0; beat[2][0] = 100;
    vpat[3] = 1'b1; beat[3][0] = 2;
    vpat[4] = 1'b0; beat[4][0] = 100;
    vpat[5] = 1'b1; beat[5][0] = 4;
    vpat[6] = 1'b1; beat[6][0] = 8;
    vpat[7] = 1'b1; beat[7][0] = 16;
    run("T4", 3, 0, 8, 0);
    chk("T4 ch0", chan(last_out, 0), 7);

    // T5: back-pressure with start asserted while holding
    clear_pat();
    vpat[0] = 1'b1; beat[0][3] = 1000; beat[0][0] = -9;
    run("T5", 1, 3, 1, 5);
    chk("T5 ch3", chan(last_out, 3), 125);
    chk("T5 ch0", chan(last_out, 0), -2);

    // T6: reset mid-accumulation
    start = 1'b1; num_ops = 9'd4; qshift = 5'd0;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = '0;
    in_data[0 +: ACC_W] = 25'd1000;
    in_data[ACC_W +: ACC_W] = 25'd77;
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("T6 busy_before_rst", longint'(busy), 1);
    rst = 1'b1;
    #1;
    chk("T6 rst busy", longint'(busy), 0);
    chk("T6 rst in_ready", longint'(in_ready), 0);
    chk("T6 rst out_valid", longint'(out_valid), 0);
    chk("T6 rst out_data", longint'(out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    clear_pat();
    vpat[0] = 1'b1; beat[0][0] = 5;
    run("T6b", 1, 0, 1, 0);
    chk("T6b ch0", chan(last_out, 0), 5);
    chk("T6b ch1", chan(last_out, 1), 0);

    // T7: empty accumulation
    clear_pat();
    run("T7", 0, 0, 0, 0);
    chk("T7 all", longint'(last_out), 0);

    // T8: ACC_W wrap then shift
    clear_pat();
    vpat[0] = 1'b1; beat[0][0] = 16777215; beat[0][1] = -40;
    vpat[1] = 1'b1; beat[1][0] = 1;        beat[1][1] = -1;
    run("T8", 2, 4, 2, 0);
`ifdef AC3_SAT_EN
    chk("T8 ch0", chan(last_out, 0), -128);
`else
    chk("T8 ch0", chan(last_out, 0), 0);
`endif
    chk("T8 ch1", chan(last_out, 1), -3);

    repeat (2) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
